sensor_acq_responder: RTL and testbench
=======================================

SENSOR_ACQ_RESPONDER -- requirements
Module: sensor_acq_responder

Interface
REQ-001 Parameter MAX_BITS, default 32, widest serial word supported.
REQ-002 Parameter CNV_PULSE, default 4, clk cycles the cnv pulse stays high.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 trigger  input  1  one-cycle acquisition start from the timing manager.
REQ-006 en  input  1  sensor enable bit from the timing manager en_bits.
REQ-007 sclk_div  input  8  sclk half-period in clk cycles.
REQ-008 nbits  input  6  serial word length.
REQ-009 timeout  input  16  max cycles waiting for sensor_busy low; 0 disables the timeout.
REQ-010 clear_err  input  1  clears the sticky error flags.
REQ-011 sensor_busy  input  1  converter busy pin, pre-synchronised.
REQ-012 sensor_miso  input  1  serial data from the converter.
REQ-013 sensor_cnv  output  1  conversion-start pulse.
REQ-014 sensor_cs_n  output  1  chip select, active-low.
REQ-015 sensor_sclk  output  1  serial clock, idle low.
REQ-016 done  output  1  level; high when idle or complete, low during acquisition.
REQ-017 data  output  MAX_BITS  last good word, right-justified, upper bits zero.
REQ-018 data_valid  output  1  one-cycle pulse when data updates.
REQ-019 err_timeout, err_overrun  output  1 each  sticky error flags.

Function
REQ-020 States IDLE, CONV, WAIT_BUSY, SHIFT, FINISH.
REQ-021 IDLE: trigger&en sampled high at cycle T -> state CONV, done=0 and sensor_cnv=1 from T+1.
REQ-022 trigger with en=0 is ignored; done stays 1.
REQ-023 CONV: sensor_cnv held high exactly CNV_PULSE cycles, then state WAIT_BUSY.
REQ-024 WAIT_BUSY: first cycle with sensor_busy=0 -> SHIFT; wait counter starts at 0 on entry.
REQ-025 Wait counter reaching timeout (timeout!=0) -> err_timeout=1, state IDLE, done=1, data unchanged, no data_valid.
REQ-026 SHIFT: cs_n low; first sclk rising edge sclk_div cycles after cs_n falls; sclk toggles every sclk_div cycles.
REQ-027 sensor_miso sampled on each sclk rising edge, MSB first, shifted into the LSB.
REQ-028 After the nbits-th rising edge: sclk returns low after sclk_div cycles, then cs_n=1 and state FINISH.
REQ-029 FINISH: one cycle; data updated, data_valid=1, done=1 in that same cycle; then state IDLE.
REQ-030 sclk_div=0 is treated as 1; nbits=0 is treated as 1; nbits>MAX_BITS is clamped to MAX_BITS.
REQ-031 trigger in any state other than IDLE: ignored for sequencing, err_overrun=1.
REQ-032 en falling in a non-IDLE state: abort next cycle to IDLE, cs_n=1, sclk=0, cnv=0, done=1, data unchanged.
REQ-033 clear_err clears both flags; an error event in the same cycle wins (flag stays set).
REQ-034 sclk_div, nbits and timeout are captured on trigger acceptance; later changes do not affect the current acquisition.

Reset
REQ-035 On reset: state IDLE, done=1 (so the timing manager's all_done can assert), sensor_cnv=0, sensor_cs_n=1, sensor_sclk=0, data=0, data_valid=0, both error flags 0, all counters 0.
REQ-036 Reset asserted mid-operation takes effect immediately (asynchronously) with the REQ-035 values.

Structure
REQ-037 A shared package holds the state enumeration and the MAX_BITS and CNV_PULSE defaults.
REQ-038 The serial engine (REQ-026 to REQ-028) is a sub-module named sensor_spi_shifter with a start/finish handshake.

Verification
REQ-039 en=1, CNV_PULSE=4, sensor_busy low 10 cycles after cnv, nbits=16, sclk_div=2, miso pattern 0xA5C3 -> data=0x0000A5C3, one data_valid, done low from T+1 until FINISH.
REQ-040 timeout=20, sensor_busy stuck high -> err_timeout=1 twenty cycles after WAIT_BUSY entry, done=1, data unchanged.
REQ-041 Second trigger during SHIFT -> err_overrun=1 and the current word completes intact; clear_err then gives err_overrun=0.
REQ-042 en dropped mid-SHIFT -> cs_n=1, sclk=0 and done=1 next cycle; no data_valid.
REQ-043 nbits=40 with MAX_BITS=32 -> exactly 32 sclk rising edges; nbits=0 -> exactly 1.
REQ-044 rst_n asserted during CONV -> all REQ-035 values immediately; trigger after release gives a normal acquisition.

Source files
------------

// File: rtl/sensor_acq_responder_pkg.sv
// Shared definitions for the sensor acquisition responder: sequencer states,
// parameter defaults and the configuration clamping helpers.
package sensor_acq_responder_pkg;

  localparam int MAX_BITS_DEF  = 32;
  localparam int CNV_PULSE_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CONV      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_FINISH    = 3'd4
  } acq_state_e;

  // A zero half-period would stall the serial clock, so it runs at one.
  function automatic logic [7:0] clamp_div(input logic [7:0] div);
    logic [7:0] res;
    if (div == 8'd0) res = 8'd1;
    else             res = div;
    return res;
  endfunction

  // Word length is at least one bit and never wider than the data register.
  function automatic logic [5:0] clamp_nbits(input logic [5:0] n, input logic [5:0] max_n);
    logic [5:0] res;
    if (n == 6'd0)      res = 6'd1;
    else if (n > max_n) res = max_n;
    else                res = n;
    return res;
  endfunction

endpackage

// File: rtl/sensor_acq_responder_if.sv
// Bundle of the timing-manager control/status signals and the converter pins.
// master: the side driving control and sensor inputs; slave: the responder.
interface sensor_acq_responder_if
  import sensor_acq_responder_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEF
) ();

  logic                trigger;
  logic                en;
  logic [7:0]          sclk_div;
  logic [5:0]          nbits;
  logic [15:0]         timeout;
  logic                clear_err;
  logic                sensor_busy;
  logic                sensor_miso;
  logic                sensor_cnv;
  logic                sensor_cs_n;
  logic                sensor_sclk;
  logic                done;
  logic [MAX_BITS-1:0] data;
  logic                data_valid;
  logic                err_timeout;
  logic                err_overrun;

  modport master (
    output trigger, en, sclk_div, nbits, timeout, clear_err, sensor_busy, sensor_miso,
    input  sensor_cnv, sensor_cs_n, sensor_sclk, done, data, data_valid, err_timeout, err_overrun
  );

  modport slave (
    input  trigger, en, sclk_div, nbits, timeout, clear_err, sensor_busy, sensor_miso,
    output sensor_cnv, sensor_cs_n, sensor_sclk, done, data, data_valid, err_timeout, err_overrun
  );

endinterface

// File: rtl/sensor_spi_shifter.sv
// Serial read engine: on start it lowers cs_n, generates nbits sclk pulses
// (idle low, half-period div cycles), samples miso on each rising edge MSB
// first, then returns sclk low, raises cs_n and pulses finish.
module sensor_spi_shifter
  import sensor_acq_responder_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [7:0]          div,
  input  logic [5:0]          nbits,
  input  logic                miso,
  output logic                cs_n,
  output logic                sclk,
  output logic                finish,
  output logic [MAX_BITS-1:0] word
);

  logic                active_r;
  logic                cs_n_r;
  logic                sclk_r;
  logic                finish_r;
  logic [MAX_BITS-1:0] word_r;
  logic [7:0]          div_cnt_r;
  logic [5:0]          edge_cnt_r;
  logic                half_done_s;

  assign half_done_s = (div_cnt_r == (div - 8'd1));

  // Half-period timing, sclk toggling, bit capture and end-of-word detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r   <= 1'b0;
      cs_n_r     <= 1'b1;
      sclk_r     <= 1'b0;
      finish_r   <= 1'b0;
      word_r     <= '0;
      div_cnt_r  <= 8'd0;
      edge_cnt_r <= 6'd0;
    end else if (abort) begin
      active_r   <= 1'b0;
      cs_n_r     <= 1'b1;
      sclk_r     <= 1'b0;
      finish_r   <= 1'b0;
      div_cnt_r  <= 8'd0;
      edge_cnt_r <= 6'd0;
    end else if (start) begin
      active_r   <= 1'b1;
      cs_n_r     <= 1'b0;
      sclk_r     <= 1'b0;
      finish_r   <= 1'b0;
      word_r     <= '0;
      div_cnt_r  <= 8'd0;
      edge_cnt_r <= 6'd0;
    end else if (active_r) begin
      finish_r <= 1'b0;
      if (half_done_s) begin
        div_cnt_r <= 8'd0;
        if (!sclk_r) begin
          sclk_r     <= 1'b1;
          word_r     <= {word_r[MAX_BITS-2:0], miso};
          edge_cnt_r <= edge_cnt_r + 6'd1;
        end else begin
          sclk_r <= 1'b0;
          // The falling edge after the last sampled bit closes the frame.
          if (edge_cnt_r == nbits) begin
            active_r <= 1'b0;
            cs_n_r   <= 1'b1;
            finish_r <= 1'b1;
          end else begin
            active_r <= 1'b1;
          end
        end
      end else begin
        div_cnt_r <= div_cnt_r + 8'd1;
      end
    end else begin
      finish_r <= 1'b0;
    end
  end

  assign cs_n   = cs_n_r;
  assign sclk   = sclk_r;
  assign finish = finish_r;
  assign word   = word_r;

endmodule

// File: rtl/sensor_acq_responder.sv
// Sensor acquisition responder: on an enabled trigger it pulses cnv, waits
// for the converter to drop busy (optionally bounded), reads the serial word
// through sensor_spi_shifter and publishes it with a one-cycle data_valid.
module sensor_acq_responder
  import sensor_acq_responder_pkg::*;
#(
  parameter int MAX_BITS  = MAX_BITS_DEF,
  parameter int CNV_PULSE = CNV_PULSE_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  sensor_acq_responder_if.slave bus
);

  localparam int               CNV_W    = (CNV_PULSE > 1) ? $clog2(CNV_PULSE) : 1;
  localparam logic [CNV_W-1:0] CNV_LAST = CNV_W'(CNV_PULSE - 1);
  localparam logic [5:0]       MAX_NB   = 6'(MAX_BITS);

  acq_state_e          state_r;
  logic                cnv_r;
  logic                done_r;
  logic [MAX_BITS-1:0] data_r;
  logic                data_valid_r;
  logic                err_timeout_r;
  logic                err_overrun_r;
  logic [CNV_W-1:0]    cnv_cnt_r;
  logic [15:0]         wait_cnt_r;
  logic [7:0]          div_r;
  logic [5:0]          nbits_r;
  logic [15:0]         tmo_r;

  logic                abort_s;
  logic                start_s;
  logic                overrun_ev_s;
  logic                timeout_ev_s;
  logic                sh_cs_n_s;
  logic                sh_sclk_s;
  logic                sh_finish_s;
  logic [MAX_BITS-1:0] sh_word_s;

  assign abort_s      = (state_r != ST_IDLE) && !bus.en;
  assign start_s      = (state_r == ST_WAIT_BUSY) && bus.en && !bus.sensor_busy;
  assign overrun_ev_s = bus.trigger && (state_r != ST_IDLE);
  // Fires on the cycle the wait counter would reach the limit, so the flag
  // shows exactly timeout cycles after WAIT_BUSY entry.
  assign timeout_ev_s = (state_r == ST_WAIT_BUSY) && bus.en && bus.sensor_busy &&
                        (tmo_r != 16'd0) && (wait_cnt_r == (tmo_r - 16'd1));

  sensor_spi_shifter #(
    .MAX_BITS (MAX_BITS)
  ) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_s),
    .abort  (abort_s),
    .div    (div_r),
    .nbits  (nbits_r),
    .miso   (bus.sensor_miso),
    .cs_n   (sh_cs_n_s),
    .sclk   (sh_sclk_s),
    .finish (sh_finish_s),
    .word   (sh_word_s)
  );

  // Acquisition sequencer: phase control, cnv pulse, busy wait and word hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnv_r        <= 1'b0;
      done_r       <= 1'b1;
      data_r       <= '0;
      data_valid_r <= 1'b0;
      cnv_cnt_r    <= '0;
      wait_cnt_r   <= 16'd0;
      div_r        <= 8'd1;
      nbits_r      <= 6'd1;
      tmo_r        <= 16'd0;
    end else begin
      data_valid_r <= 1'b0;
      if (abort_s) begin
        state_r    <= ST_IDLE;
        cnv_r      <= 1'b0;
        done_r     <= 1'b1;
        cnv_cnt_r  <= '0;
        wait_cnt_r <= 16'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (bus.trigger && bus.en) begin
              state_r   <= ST_CONV;
              cnv_r     <= 1'b1;
              done_r    <= 1'b0;
              cnv_cnt_r <= '0;
              div_r     <= clamp_div(bus.sclk_div);
              nbits_r   <= clamp_nbits(bus.nbits, MAX_NB);
              tmo_r     <= bus.timeout;
            end else begin
              done_r <= 1'b1;
            end
          end
          ST_CONV: begin
            if (cnv_cnt_r == CNV_LAST) begin
              state_r    <= ST_WAIT_BUSY;
              cnv_r      <= 1'b0;
              cnv_cnt_r  <= '0;
              wait_cnt_r <= 16'd0;
            end else begin
              cnv_cnt_r <= cnv_cnt_r + CNV_W'(1);
            end
          end
          ST_WAIT_BUSY: begin
            if (!bus.sensor_busy) begin
              state_r    <= ST_SHIFT;
              wait_cnt_r <= 16'd0;
            end else if (timeout_ev_s) begin
              state_r    <= ST_IDLE;
              done_r     <= 1'b1;
              wait_cnt_r <= 16'd0;
            end else begin
              wait_cnt_r <= wait_cnt_r + 16'd1;
            end
          end
          ST_SHIFT: begin
            if (sh_finish_s) begin
              state_r      <= ST_FINISH;
              data_r       <= sh_word_s;
              data_valid_r <= 1'b1;
              done_r       <= 1'b1;
            end else begin
              state_r <= ST_SHIFT;
            end
          end
          ST_FINISH: begin
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
            cnv_r   <= 1'b0;
            done_r  <= 1'b1;
          end
        endcase
      end
    end
  end

  // Sticky error flags; a new event outranks clear_err in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout_r <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      err_timeout_r <= timeout_ev_s | (err_timeout_r & ~bus.clear_err);
      err_overrun_r <= overrun_ev_s | (err_overrun_r & ~bus.clear_err);
    end
  end

  assign bus.sensor_cnv  = cnv_r;
  assign bus.sensor_cs_n = sh_cs_n_s;
  assign bus.sensor_sclk = sh_sclk_s;
  assign bus.done        = done_r;
  assign bus.data        = data_r;
  assign bus.data_valid  = data_valid_r;
  assign bus.err_timeout = err_timeout_r;
  assign bus.err_overrun = err_overrun_r;

endmodule

// File: tb/tb_sensor_acq_responder.sv
// Directed bench for sensor_acq_responder: a table of acquisitions plus
// hand-written sequences for overrun, abort, timeout and mid-run reset.
module tb_sensor_acq_responder;
  import sensor_acq_responder_pkg::*;

  typedef struct {
    logic [5:0]  nbits;
    logic [7:0]  div;
    logic [31:0] pat;
    int          busy_dly;
    logic [31:0] exp_data;
    int          exp_edges;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sensor_acq_responder_if #(.MAX_BITS(32)) bus ();

  sensor_acq_responder #(.MAX_BITS(32), .CNV_PULSE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          rise_cnt = 0;
  int          dv_cnt = 0;
  logic [63:0] pattern = 64'd0;
  logic [63:0] sreg = 64'd0;
  logic        cs_q = 1'b1;
  logic [31:0] last_data = 32'd0;
  vec_t        vt [6];

  assign bus.sensor_miso = sreg[63];

  // Converter model: loads the word when cs_n falls, shifts on each sclk fall
  always @(posedge bus.sensor_cs_n or negedge bus.sensor_cs_n or negedge bus.sensor_sclk) begin
    if (bus.sensor_cs_n !== 1'b0) cs_q = 1'b1;
    else if (cs_q) begin
      sreg = pattern;
      cs_q = 1'b0;
    end else sreg = sreg << 1;
  end

  // Count sclk rising edges
  always @(posedge bus.sensor_sclk) rise_cnt <= rise_cnt + 1;

  // Count data_valid pulses
  always @(negedge clk) if (bus.data_valid === 1'b1) dv_cnt <= dv_cnt + 1;

  // Hard stop if something hangs outside the bounded waits
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Trigger an acquisition, then scramble the config inputs to prove capture
  task automatic start_acq(input logic [5:0] nb, input logic [7:0] dv, input logic [15:0] tmo,
                           input logic [31:0] pat, input int eff, input string tag);
    @(negedge clk);
    bus.nbits       = nb;
    bus.sclk_div    = dv;
    bus.timeout     = tmo;
    pattern         = {32'd0, pat} << (64 - eff);
    bus.sensor_busy = 1'b1;
    bus.en          = 1'b1;
    bus.trigger     = 1'b1;
    @(negedge clk);
    bus.trigger  = 1'b0;
    bus.nbits    = 6'd5;
    bus.sclk_div = 8'd7;
    bus.timeout  = 16'd3;
    check({tag, "_done_low"}, bus.done, 1'b0);
    check({tag, "_cnv_high"}, bus.sensor_cnv, 1'b1);
  endtask

  // Measure the cnv pulse; returns at the first WAIT_BUSY cycle
  task automatic wait_cnv(output int len);
    len = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.sensor_cnv) len++;
      else break;
    end
  endtask

  task automatic wait_dv(output bit seen, output bit done_ok);
    seen = 1'b0;
    done_ok = 1'b1;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (bus.data_valid) seen = 1'b1;
      else if (bus.done) done_ok = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int base_r, base_d, len;
    bit seen, done_ok;
    base_r = rise_cnt;
    base_d = dv_cnt;
    start_acq(v.nbits, v.div, 16'd0, v.pat, v.exp_edges, tag);
    wait_cnv(len);
    check({tag, "_cnv_len"}, len, 4);
    repeat (v.busy_dly) @(negedge clk);
    bus.sensor_busy = 1'b0;
    wait_dv(seen, done_ok);
    check({tag, "_dv_seen"}, seen, 1'b1);
    check({tag, "_done_held_low"}, done_ok, 1'b1);
    check({tag, "_done_at_dv"}, bus.done, 1'b1);
    check({tag, "_data"}, bus.data, v.exp_data);
    @(negedge clk);
    check({tag, "_dv_one_cycle"}, bus.data_valid, 1'b0);
    @(negedge clk);
    check({tag, "_dv_count"}, dv_cnt - base_d, 1);
    check({tag, "_sclk_edges"}, rise_cnt - base_r, v.exp_edges);
    bus.sensor_busy = 1'b1;
    last_data = v.exp_data;
  endtask

  initial begin
    int base_r, base_d, len;
    bit seen, done_ok;

    vt[0] = '{6'd16, 8'd2, 32'h0000A5C3, 10, 32'h0000A5C3, 16};
    vt[1] = '{6'd8,  8'd1, 32'h0000003C, 0,  32'h0000003C, 8};
    vt[2] = '{6'd40, 8'd1, 32'hDEADBEEF, 3,  32'hDEADBEEF, 32};
    vt[3] = '{6'd0,  8'd0, 32'h00000001, 2,  32'h00000001, 1};
    vt[4] = '{6'd12, 8'd3, 32'h00000F0A, 5,  32'h00000F0A, 12};
    vt[5] = '{6'd32, 8'd1, 32'h80000001, 1,  32'h80000001, 32};

    bus.trigger = 1'b0;
    bus.en = 1'b0;
    bus.sclk_div = 8'd1;
    bus.nbits = 6'd8;
    bus.timeout = 16'd0;
    bus.clear_err = 1'b0;
    bus.sensor_busy = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_done", bus.done, 1'b1);
    check("rst_cnv", bus.sensor_cnv, 1'b0);
    check("rst_cs_n", bus.sensor_cs_n, 1'b1);
    check("rst_sclk", bus.sensor_sclk, 1'b0);
    check("rst_data", bus.data, 32'd0);
    check("rst_dv", bus.data_valid, 1'b0);
    check("rst_err_tmo", bus.err_timeout, 1'b0);
    check("rst_err_ovr", bus.err_overrun, 1'b0);
    rst_n = 1'b1;

    // Trigger with en low is ignored
    @(negedge clk);
    bus.trigger = 1'b1;
    @(negedge clk);
    bus.trigger = 1'b0;
    check("en0_done", bus.done, 1'b1);
    check("en0_cnv", bus.sensor_cnv, 1'b0);
    check("en0_no_ovr", bus.err_overrun, 1'b0);

    // Table of normal acquisitions
    for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Second trigger during SHIFT: overrun flagged, word still intact
    base_r = rise_cnt;
    start_acq(6'd16, 8'd2, 16'd0, 32'h00001234, 16, "ovr");
    wait_cnv(len);
    bus.sensor_busy = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.sensor_cs_n == 1'b0) seen = 1'b1;
    end
    check("ovr_cs_low", seen, 1'b1);
    bus.trigger = 1'b1;
    @(negedge clk);
    bus.trigger = 1'b0;
    check("ovr_flag", bus.err_overrun, 1'b1);
    wait_dv(seen, done_ok);
    check("ovr_dv_seen", seen, 1'b1);
    check("ovr_data", bus.data, 32'h00001234);
    repeat (5) @(negedge clk);
    check("ovr_edges", rise_cnt - base_r, 16);
    check("ovr_no_restart", bus.done, 1'b1);
    bus.sensor_busy = 1'b1;
    last_data = 32'h00001234;
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    check("ovr_cleared", bus.err_overrun, 1'b0);

    // en dropped mid-SHIFT; also trigger and clear_err in the same cycle
    base_r = rise_cnt;
    base_d = dv_cnt;
    start_acq(6'd16, 8'd2, 16'd0, 32'h0000FFFF, 16, "abt");
    wait_cnv(len);
    bus.sensor_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.trigger = 1'b1;
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.trigger = 1'b0;
    bus.clear_err = 1'b0;
    check("abt_event_beats_clear", bus.err_overrun, 1'b1);
    for (int i = 0; i < 100 && (rise_cnt - base_r) < 3; i++) @(negedge clk);
    check("abt_reached_edges", rise_cnt - base_r, 3);
    bus.en = 1'b0;
    @(negedge clk);
    check("abt_cs_n", bus.sensor_cs_n, 1'b1);
    check("abt_sclk", bus.sensor_sclk, 1'b0);
    check("abt_done", bus.done, 1'b1);
    repeat (30) @(negedge clk);
    check("abt_no_dv", dv_cnt - base_d, 0);
    check("abt_data_kept", bus.data, last_data);
    check("abt_edges_frozen", rise_cnt - base_r, 3);
    bus.sensor_busy = 1'b1;
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    check("abt_cleared", bus.err_overrun, 1'b0);

    // Busy stuck high with timeout=20
    base_r = rise_cnt;
    start_acq(6'd16, 8'd2, 16'd20, 32'h0000AAAA, 16, "tmo");
    wait_cnv(len);
    repeat (19) @(negedge clk);
    check("tmo_not_yet", bus.err_timeout, 1'b0);
    check("tmo_done_low", bus.done, 1'b0);
    @(negedge clk);
    check("tmo_flag", bus.err_timeout, 1'b1);
    check("tmo_done", bus.done, 1'b1);
    check("tmo_data_kept", bus.data, last_data);
    check("tmo_no_edges", rise_cnt - base_r, 0);
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    check("tmo_cleared", bus.err_timeout, 1'b0);

    // Asynchronous reset during CONV, then a normal acquisition
    start_acq(6'd16, 8'd2, 16'd0, 32'h00005555, 16, "rst");
    bus.trigger = 1'b1;
    @(negedge clk);
    bus.trigger = 1'b0;
    check("rst_conv_ovr", bus.err_overrun, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_cnv", bus.sensor_cnv, 1'b0);
    check("mrst_done", bus.done, 1'b1);
    check("mrst_cs_n", bus.sensor_cs_n, 1'b1);
    check("mrst_sclk", bus.sensor_sclk, 1'b0);
    check("mrst_data", bus.data, 32'd0);
    check("mrst_dv", bus.data_valid, 1'b0);
    check("mrst_err_ovr", bus.err_overrun, 1'b0);
    check("mrst_err_tmo", bus.err_timeout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vt[0], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
